// File: rtl/proc_pkg.sv
// Shared processor constants for the multiply/divide sequencing logic:
// R-type opcode, MUL/DIV function codes, controller state encoding and
// the default busy-time limit.
package proc_pkg;

    localparam logic [4:0] OPC_RTYPE       = 5'b00000;
    localparam logic [4:0] ALU_MUL         = 5'b00110;
    localparam logic [4:0] ALU_DIV         = 5'b00111;
    localparam int         TIMEOUT_DEFAULT = 40;
    localparam int         MD_CNT_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // True when the execute-stage instruction is an R-type MUL or DIV.
    function automatic logic is_multdiv(input logic [4:0] opc, input logic [4:0] aluop);
        return (opc == OPC_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/md_timer.sv
// Busy-time counter for the multdiv controller: synchronous clear,
// count enable, saturation at the terminal value, terminal-count flag.
module md_timer
    import proc_pkg::*;
#(
    parameter int TC_VALUE = TIMEOUT_DEFAULT - 1
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_clear,
    input  logic                i_enable,
    output logic [MD_CNT_W-1:0] o_count,
    output logic                o_tc
);

    localparam logic [MD_CNT_W-1:0] TC_VAL = MD_CNT_W'(TC_VALUE);

    logic [MD_CNT_W-1:0] r_count;

    // Count while enabled; clear has priority; hold once the terminal value is reached.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= {MD_CNT_W{1'b0}};
        end else if (i_clear) begin
            r_count <= {MD_CNT_W{1'b0}};
        end else if (i_enable && (r_count != TC_VAL)) begin
            r_count <= r_count + MD_CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide controller: issues start pulses to the multdiv datapath,
// stalls the pipeline while it works, and writes back the result (or the
// error status) once, with a timeout that forces completion as an error.
module multdiv_ctrl
    import proc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       x_valid,
    input  logic [4:0] opcode,
    input  logic [4:0] aluop_in,
    input  logic       flush,
    input  logic       md_ready,
    input  logic       md_exception,
    output logic       ctrl_mult,
    output logic       ctrl_div,
    output logic       stall,
    output logic       wb_en,
    output logic       wb_exc,
    output logic       op_is_div
);

    md_state_t           r_state;
    md_state_t           w_next_state;
    logic                r_exc;
    logic                r_op_is_div;
    logic                r_ctrl_mult;
    logic                r_ctrl_div;
    logic                w_issue;
    logic                w_done_set;
    logic                w_done_exc;
    logic                w_stall;
    logic                w_wb_en;
    logic                w_wb_exc;
    logic [MD_CNT_W-1:0] w_count;
    logic                w_tc;

    md_timer #(
        .TC_VALUE (TIMEOUT - 1)
    ) u_md_timer (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_clear   (w_issue),
        .i_enable  (r_state == ST_BUSY),
        .o_count   (w_count),
        .o_tc      (w_tc)
    );

    // Controller state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, issue decision and the combinational stall/writeback outputs.
    // Issue is gated by reset_n so stall drops the moment reset asserts.
    // In BUSY, a count of zero marks the start-pulse cycle, whose md_ready is stale.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_done_set   = 1'b0;
        w_done_exc   = 1'b0;
        w_wb_en      = 1'b0;
        w_wb_exc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reset_n && x_valid && !flush && is_multdiv(opcode, aluop_in)) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (md_ready && (w_count != {MD_CNT_W{1'b0}})) begin
                    w_next_state = ST_DONE;
                    w_done_set   = 1'b1;
                    w_done_exc   = md_exception;
                end else if (w_tc) begin
                    w_next_state = ST_DONE;
                    w_done_set   = 1'b1;
                    w_done_exc   = 1'b1;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_wb_en      = !flush;
                w_wb_exc     = !flush && r_exc;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        w_stall = w_issue || (r_state == ST_BUSY);
    end

    // Start pulses, operation type and completion status captured at issue/completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_op_is_div <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            r_ctrl_mult <= w_issue && !aluop_in[0];
            r_ctrl_div  <= w_issue && aluop_in[0];
            if (w_issue) begin
                r_op_is_div <= aluop_in[0];
                r_exc       <= 1'b0;
            end else if (w_done_set) begin
                r_op_is_div <= r_op_is_div;
                r_exc       <= w_done_exc;
            end else begin
                r_op_is_div <= r_op_is_div;
                r_exc       <= r_exc;
            end
        end
    end

    assign ctrl_mult = r_ctrl_mult;
    assign ctrl_div  = r_ctrl_div;
    assign op_is_div = r_op_is_div;
    assign stall     = w_stall;
    assign wb_en     = w_wb_en;
    assign wb_exc    = w_wb_exc;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: a cycle-count model of the
// controller's rules checked every cycle, plus directed scenarios with
// hand-computed cycle numbers for pulses, stalls and writebacks.
module tb_multdiv_ctrl;
    import proc_pkg::*;

    localparam int TO = 40;

    logic       clock        = 1'b0;
    logic       reset_n      = 1'b0;
    logic       x_valid      = 1'b0;
    logic [4:0] opcode       = 5'b00000;
    logic [4:0] aluop_in     = 5'b00000;
    logic       flush        = 1'b0;
    logic       md_ready     = 1'b0;
    logic       md_exception = 1'b0;
    logic       ctrl_mult, ctrl_div, stall, wb_en, wb_exc, op_is_div;

    int n_cmp = 0;
    int n_bad = 0;

    // model: busy flag with cycles-in-busy count (1 = first busy cycle), done flag
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_exc  = 1'b0;
    bit m_div  = 1'b0;
    int m_n    = 0;

    logic s_stall, s_mult, s_div, s_wb, s_wbx, s_opdiv;

    always #5 clock = ~clock;

    multdiv_ctrl #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .x_valid      (x_valid),
        .opcode       (opcode),
        .aluop_in     (aluop_in),
        .flush        (flush),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_exc       (wb_exc),
        .op_is_div    (op_is_div)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_issue();
        return reset_n && !m_busy && !m_done && x_valid && !flush &&
               (opcode == 5'b00000) && ((aluop_in == 5'b00110) || (aluop_in == 5'b00111));
    endfunction

    // model update: rules applied at each rising edge, cleared immediately by reset
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_exc <= 1'b0; m_div <= 1'b0; m_n <= 0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy <= 1'b0;
            end else if (md_ready && (m_n >= 2)) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_exc <= md_exception;
            end else if (m_n == TO) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_exc <= 1'b1;
            end else begin
                m_n <= m_n + 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (model_issue()) begin
            m_busy <= 1'b1; m_n <= 1; m_div <= aluop_in[0]; m_exc <= 1'b0;
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        chk("stall",     stall,     model_issue() || m_busy);
        chk("ctrl_mult", ctrl_mult, m_busy && (m_n == 1) && !m_div);
        chk("ctrl_div",  ctrl_div,  m_busy && (m_n == 1) && m_div);
        chk("wb_en",     wb_en,     m_done && !flush);
        chk("wb_exc",    wb_exc,    m_done && !flush && m_exc);
        chk("op_is_div", op_is_div, m_div);
    end

    task automatic tick();
        @(negedge clock);
        s_stall = stall; s_mult = ctrl_mult; s_div = ctrl_div;
        s_wb = wb_en; s_wbx = wb_exc; s_opdiv = op_is_div;
        @(posedge clock);
        #1;
    endtask

    // One directed operation; cycle 0 is the issue cycle.
    task automatic run_op(input logic div, input int hold, input int ready_at, input logic ign1,
                          input logic exc_in, input int flush_at, input int ncyc,
                          output int pulse_at, output logic pulse_div, output int wb_at,
                          output logic wbx, output int stall_n);
        pulse_at = -1; pulse_div = 1'b0; wb_at = -1; wbx = 1'b0; stall_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            x_valid      = (c <= hold);
            opcode       = 5'b00000;
            aluop_in     = div ? ALU_DIV : ALU_MUL;
            md_ready     = (c == ready_at) || (ign1 && (c == 1));
            md_exception = md_ready && exc_in;
            flush        = (c == flush_at);
            tick();
            if (s_mult || s_div) begin pulse_at = c; pulse_div = s_div; end
            if (s_wb) begin wb_at = c; wbx = s_wbx; end
            if ((c >= 1) && s_stall) stall_n++;
        end
        x_valid = 1'b0; md_ready = 1'b0; md_exception = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   p, w, sn;
        logic pd, wx;

        #3;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mult", ctrl_mult, 1'b0);
        chk("rst_div", ctrl_div, 1'b0);
        chk("rst_wb", wb_en, 1'b0);
        chk("rst_wbx", wb_exc, 1'b0);
        chk("rst_opdiv", op_is_div, 1'b0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        tick(); tick();

        // non-multdiv instructions
        x_valid = 1'b1; opcode = 5'b00101; aluop_in = 5'b00110;
        tick();
        chk("opc_stall", s_stall, 1'b0);
        opcode = 5'b00000; aluop_in = 5'b00000;
        tick();
        chk("alu0_stall", s_stall, 1'b0);
        x_valid = 1'b0; aluop_in = ALU_MUL;
        tick();
        chk("novalid_stall", s_stall, 1'b0);
        tick();
        chk("novalid_pulse", s_mult || s_div, 1'b0);

        // MUL, stale md_ready in pulse cycle, real md_ready cycle 17, instr held into DONE
        run_op(1'b0, 18, 17, 1'b1, 1'b0, -1, 22, p, pd, w, wx, sn);
        chki("mul_pulse_cyc", p, 1); chk("mul_pulse_kind", pd, 1'b0);
        chki("mul_wb_cyc", w, 18); chk("mul_wbx", wx, 1'b0);
        chki("mul_stall_n", sn, 17); chk("mul_opdiv", s_opdiv, 1'b0);

        // DIV with exception at md_ready
        run_op(1'b1, 0, 5, 1'b1, 1'b1, -1, 8, p, pd, w, wx, sn);
        chki("div_pulse_cyc", p, 1); chk("div_pulse_kind", pd, 1'b1);
        chki("div_wb_cyc", w, 6); chk("div_wbx", wx, 1'b1);
        chki("div_stall_n", sn, 5); chk("div_opdiv", s_opdiv, 1'b1);

        // timeout: counter is 0 in busy cycle 1, reaches TO-1 in busy cycle TO
        run_op(1'b0, 0, -1, 1'b0, 1'b0, -1, TO + 4, p, pd, w, wx, sn);
        chki("to_pulse_cyc", p, 1);
        chki("to_wb_cyc", w, TO + 1); chk("to_wbx", wx, 1'b1);
        chki("to_stall_n", sn, TO);

        // flush coincident with md_ready
        run_op(1'b0, 0, 6, 1'b0, 1'b0, 6, 10, p, pd, w, wx, sn);
        chki("fl_rdy_wb", w, -1); chki("fl_rdy_stall_n", sn, 6);

        // flush in DONE
        run_op(1'b1, 0, 3, 1'b0, 1'b0, 4, 7, p, pd, w, wx, sn);
        chki("fl_done_wb", w, -1); chki("fl_done_stall_n", sn, 3);

        // flush in the would-be issue cycle
        run_op(1'b0, 0, -1, 1'b0, 1'b0, 0, 4, p, pd, w, wx, sn);
        chki("fl_issue_pulse", p, -1); chki("fl_issue_stall_n", sn, 0);

        // back-to-back: second op issues the cycle after DONE, then flushed
        run_op(1'b1, 4, 2, 1'b0, 1'b0, 6, 8, p, pd, w, wx, sn);
        chki("b2b_wb_cyc", w, 3); chki("b2b_pulse_cyc", p, 5);
        chk("b2b_pulse_kind", pd, 1'b1); chki("b2b_stall_n", sn, 5);

        // reset mid-BUSY with a MUL waiting in execute
        x_valid = 1'b1; opcode = 5'b00000; aluop_in = ALU_MUL;
        tick();
        x_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", s_stall, 1'b1);
        #2;
        reset_n = 1'b0; x_valid = 1'b1;
        #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_mult", ctrl_mult, 1'b0);
        chk("arst_div", ctrl_div, 1'b0);
        chk("arst_wb", wb_en, 1'b0);
        chk("arst_wbx", wb_exc, 1'b0);
        chk("arst_opdiv", op_is_div, 1'b0);
        tick();
        chk("rst_hold_stall", s_stall, 1'b0);
        reset_n = 1'b1;
        run_op(1'b0, 0, 3, 1'b0, 1'b0, -1, 6, p, pd, w, wx, sn);
        chki("post_rst_pulse", p, 1); chk("post_rst_kind", pd, 1'b0);
        chki("post_rst_wb", w, 4); chk("post_rst_wbx", wx, 1'b0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
